// File: rtl/logicap_pkg.sv
// rtl/logicap_pkg.sv - shared state type and default widths for the capture sink
package logicap_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } sink_state_e;

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - simple dual-port sample storage, one write port, registered read port
module sample_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Write on request; read data only updates on rd_en so it holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sample_sink.sv
// rtl/sample_sink.sv - ring-buffer sample capture with oldest-first readout; SAMPLE_SINK_DROP_CNT_EN adds drop_count
module sample_sink
    import logicap_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [ADDR_W:0]   buffer_size,
    input  logic              arm,
    input  logic              capture_done,
    input  logic              abort,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              wrapped,
    output logic              rd_done
`ifdef SAMPLE_SINK_DROP_CNT_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    sink_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]   load_cnt_q, load_cnt_d;
    logic              wrapped_q, wrapped_d;
    logic              rv_q, rv_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;
    logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
    logic              rd_done_q, rd_done_d;

    logic              beat, wr_last, rd_last, out_fire, move, issue, arm_accept;
    logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic [DATA_W-1:0] ram_rd_data;

    sample_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (beat),
        .wr_addr (wr_ptr_q),
        .wr_data (s_tdata),
        .rd_en   (issue),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // Handshake decode and the read pipeline: RAM output register feeds the output register.
    always_comb begin
        beat       = s_tvalid && (state_q == ST_FILL);
        wr_last    = ({1'b0, wr_ptr_q} == (n_q - ONE));
        rd_last    = ({1'b0, rd_ptr_q} == (n_q - ONE));
        wr_ptr_inc = wr_last ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_inc = rd_last ? '0 : rd_ptr_q + 1'b1;
        out_fire   = m_tvalid_q && m_tready;
        move       = rv_q && (!m_tvalid_q || m_tready);
        issue      = (state_q == ST_DRAIN) && (issue_cnt_q != count_q) && (!rv_q || move);
        arm_accept = (state_q == ST_IDLE) && arm && !abort;
    end

    // Next-state logic for the fill/drain sequencer; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        n_d         = n_q;
        issue_cnt_d = issue_cnt_q;
        load_cnt_d  = load_cnt_q;
        wrapped_d   = wrapped_q;
        rv_d        = rv_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        m_tdata_d   = m_tdata_q;
        rd_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d   = ST_FILL;
                    wr_ptr_d  = '0;
                    count_d   = '0;
                    wrapped_d = 1'b0;
                    n_d       = buffer_size;
                end
            end
            ST_FILL: begin
                if (beat) begin
                    wr_ptr_d = wr_ptr_inc;
                    if (wr_last) begin
                        wrapped_d = 1'b1;
                    end
                    if (count_q != n_q) begin
                        count_d = count_q + 1'b1;
                    end
                end
                // Decide on the post-beat count/pointer so a coincident beat is included.
                if (capture_done) begin
                    if (count_d == '0) begin
                        state_d   = ST_IDLE;
                        rd_done_d = 1'b1;
                    end else begin
                        state_d     = ST_DRAIN;
                        rd_ptr_d    = wrapped_d ? wr_ptr_d : '0;
                        issue_cnt_d = '0;
                        load_cnt_d  = '0;
                        rv_d        = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (issue) begin
                    rd_ptr_d    = rd_ptr_inc;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                rv_d = issue || (rv_q && !move);
                if (move) begin
                    m_tdata_d  = ram_rd_data;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = (load_cnt_q == (count_q - ONE));
                    load_cnt_d = load_cnt_q + 1'b1;
                end else if (out_fire) begin
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                end
                if (out_fire && m_tlast_q) begin
                    state_d    = ST_IDLE;
                    rd_done_d  = 1'b1;
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                    rv_d       = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            rv_d       = 1'b0;
            rd_done_d  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            n_q         <= '0;
            issue_cnt_q <= '0;
            load_cnt_q  <= '0;
            wrapped_q   <= 1'b0;
            rv_q        <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            n_q         <= n_d;
            issue_cnt_q <= issue_cnt_d;
            load_cnt_q  <= load_cnt_d;
            wrapped_q   <= wrapped_d;
            rv_q        <= rv_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tdata_q   <= m_tdata_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign s_tready = (state_q == ST_FILL);
    assign busy     = (state_q != ST_IDLE);
    assign wrapped  = wrapped_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tdata  = m_tdata_q;
    assign rd_done  = rd_done_q;

`ifdef SAMPLE_SINK_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Count samples offered while not filling; cleared by an accepted arm.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (arm_accept) begin
            drop_cnt_d = '0;
        end else if (s_tvalid && (state_q != ST_FILL) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    logic unused_arm_accept;
    assign unused_arm_accept = arm_accept;
`endif

endmodule

// File: tb/tb_sample_sink.sv
// tb/tb_sample_sink.sv - self-checking bench for sample_sink with a queue-based ring model
module tb_sample_sink;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [AW:0]   buffer_size = '0;
    logic          arm = 1'b0;
    logic          capture_done = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          busy;
    logic          wrapped;
    logic          rd_done;
`ifdef SAMPLE_SINK_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    sample_sink #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .buffer_size  (buffer_size),
        .arm          (arm),
        .capture_done (capture_done),
        .abort        (abort),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy         (busy),
        .wrapped      (wrapped),
        .rd_done      (rd_done)
`ifdef SAMPLE_SINK_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 fill, 2 drain.
    int          mstate = 0;
    int          mn = 0;
    logic [31:0] fill_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit          exp_rd_done = 0;
    bit          exp_wrapped = 0;
    int          drain_age = 0;
    int          rd_done_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    bit          was_reset = 0;

    always @(negedge clk) begin
        if (was_reset) begin
            chk1("rst_m_tvalid", m_tvalid, 1'b0);
            chk1("rst_m_tlast", m_tlast, 1'b0);
            chk1("rst_s_tready", s_tready, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_wrapped", wrapped, 1'b0);
            chk1("rst_rd_done", rd_done, 1'b0);
            chk32("rst_m_tdata", m_tdata, 32'h0);
        end
        was_reset = reset;
        if (reset) begin
            mstate = 0;
            exp_q.delete();
            exp_rd_done = 0;
            prev_stall = 0;
        end else begin
            chk1("rd_done", rd_done, exp_rd_done);
            if (rd_done) rd_done_cnt++;
            chk1("s_tready", s_tready, mstate == 1);
            chk1("busy", busy, mstate != 0);
            if (mstate != 2) begin
                chk1("m_tvalid_idle", m_tvalid, 1'b0);
                chk1("m_tlast_idle", m_tlast, 1'b0);
            end
            if (mstate == 1) chk1("wrapped_fill", wrapped, fill_q.size() >= mn);
            if (mstate == 2) begin
                drain_age++;
                chk1("wrapped_drain", wrapped, exp_wrapped);
                if (drain_age < 3) chk1("first_valid_lat", m_tvalid, 1'b0);
                else if (exp_q.size() > 0) chk1("no_bubble", m_tvalid, 1'b1);
                if (prev_stall) begin
                    chk1("stall_valid", m_tvalid, 1'b1);
                    chk32("stall_data", m_tdata, prev_data);
                end
            end
            exp_rd_done = 0;
            prev_stall  = (mstate == 2) && m_tvalid && !m_tready;
            prev_data   = m_tdata;
            if (abort) begin
                mstate = 0;
                exp_q.delete();
                prev_stall = 0;
            end else begin
                case (mstate)
                    0: if (arm) begin
                        mstate = 1;
                        fill_q.delete();
                        mn = int'(buffer_size);
                    end
                    1: begin
                        if (s_tvalid) fill_q.push_back(s_tdata);
                        if (capture_done) begin
                            int k;
                            k = (fill_q.size() < mn) ? fill_q.size() : mn;
                            exp_q.delete();
                            for (int i = fill_q.size() - k; i < fill_q.size(); i++)
                                exp_q.push_back(fill_q[i]);
                            exp_wrapped = fill_q.size() >= mn;
                            if (k == 0) begin
                                mstate = 0;
                                exp_rd_done = 1;
                            end else begin
                                mstate = 2;
                                drain_age = 0;
                            end
                        end
                    end
                    default: if (m_tvalid && m_tready) begin
                        if (exp_q.size() == 0) begin
                            chk1("extra_beat", 1'b1, 1'b0);
                        end else begin
                            logic [31:0] e;
                            e = exp_q.pop_front();
                            chk32("m_tdata", m_tdata, e);
                            chk1("m_tlast", m_tlast, exp_q.size() == 0);
                            got_q.push_back(m_tdata);
                            if (exp_q.size() == 0) begin
                                mstate = 0;
                                exp_rd_done = 1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int n);
        buffer_size = (AW + 1)'(n);
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        s_tvalid = 1'b1;
        s_tdata  = d;
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic cap();
        capture_done = 1'b1;
        step();
        capture_done = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int mode);
        int guard;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        guard = 0;
        while ((mstate != 0 || busy) && guard < 2000) begin
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = pat[guard % 4];
                default: m_tready = ($urandom_range(0, 2) != 0);
            endcase
            step();
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=busy required=idle t=%0t", $time);
        end
        m_tready = 1'b1;
        step();
    endtask

    task automatic check_got(input string name, input logic [31:0] e[$]);
        chk32({name, "_len"}, 32'(got_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < got_q.size(); i++)
            chk32(name, got_q[i], e[i]);
    endtask

    initial begin
        logic [31:0] lit[$];
        int rd0;
        repeat (3) step();
        reset = 1'b0;
        step();

`ifdef SAMPLE_SINK_DROP_CNT_EN
        s_tvalid = 1'b1;
        repeat (3) step();
        s_tvalid = 1'b0;
        @(negedge clk);
        chk32("drop_count_3", 32'(drop_count), 32'd3);
        step();
        do_arm(4);
        @(negedge clk);
        chk32("drop_count_arm", 32'(drop_count), 32'd0);
        step();
        cap();
        step();
`endif

        // N=8, five beats, no wrap
        got_q.delete(); rd0 = rd_done_cnt;
        do_arm(8);
        for (int i = 1; i <= 5; i++) send(32'(i));
        cap();
        chk1("t1_wrapped", wrapped, 1'b0);
        drain(0);
        lit = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        check_got("t1_data", lit);
        chk32("t1_rd_done", 32'(rd_done_cnt - rd0), 32'd1);

        // N=4, ten beats, wrapped oldest-first
        got_q.delete(); rd0 = rd_done_cnt;
        do_arm(4);
        for (int i = 0; i < 10; i++) send(32'(i));
        cap();
        chk1("t2_wrapped", wrapped, 1'b1);
        drain(0);
        lit = '{32'h6, 32'h7, 32'h8, 32'h9};
        check_got("t2_data", lit);
        chk32("t2_rd_done", 32'(rd_done_cnt - rd0), 32'd1);

        // N=4 full, ready toggling 1,0,0,1
        got_q.delete();
        do_arm(4);
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i));
        cap();
        drain(1);
        lit = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        check_got("t3_data", lit);

        // abort after two drain beats, then a fresh fill
        got_q.delete(); rd0 = rd_done_cnt;
        do_arm(8);
        for (int i = 0; i < 8; i++) send(32'hB0 + 32'(i));
        cap();
        begin
            int g;
            g = 0;
            while (got_q.size() < 2 && g < 100) begin step(); g++; end
        end
        m_tready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        chk1("t4_abort_valid", m_tvalid, 1'b0);
        chk1("t4_abort_busy", busy, 1'b0);
        step();
        chk32("t4_beats", 32'(got_q.size()), 32'd2);
        chk32("t4_rd_done", 32'(rd_done_cnt - rd0), 32'd0);
        got_q.delete();
        do_arm(4);
        for (int i = 1; i <= 3; i++) send(32'h10 + 32'(i));
        cap();
        drain(0);
        lit = '{32'h11, 32'h12, 32'h13};
        check_got("t4_refill", lit);

        // capture_done with nothing captured
        got_q.delete(); rd0 = rd_done_cnt;
        do_arm(4);
        cap();
        step();
        step();
        chk32("t5_beats", 32'(got_q.size()), 32'd0);
        chk32("t5_rd_done", 32'(rd_done_cnt - rd0), 32'd1);

        // beat coincident with capture_done, and an ignored re-arm during fill
        got_q.delete();
        do_arm(4);
        send(32'hC1);
        buffer_size = 5'd8;
        arm = 1'b1; step(); arm = 1'b0;
        s_tvalid = 1'b1; s_tdata = 32'hC2; capture_done = 1'b1;
        step();
        s_tvalid = 1'b0; capture_done = 1'b0;
        drain(0);
        lit = '{32'hC1, 32'hC2};
        check_got("t6_data", lit);

        // N=1 and full physical depth
        do_arm(1);
        for (int i = 0; i < 3; i++) send($urandom);
        cap();
        drain(2);
        do_arm(16);
        for (int i = 0; i < 20; i++) send($urandom);
        cap();
        drain(2);

        // reset mid-drain
        do_arm(8);
        for (int i = 0; i < 6; i++) send($urandom);
        cap();
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            int n, b, sent;
            bit done;
            n = $urandom_range(1, 16);
            b = $urandom_range(0, 40);
            sent = 0;
            done = 0;
            do_arm(n);
            while (sent < b) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
                s_tdata  = $urandom;
                if (s_tvalid) sent++;
                if (sent == b && s_tvalid && $urandom_range(0, 1) == 1) begin
                    capture_done = 1'b1;
                    done = 1;
                end
                step();
            end
            s_tvalid = 1'b0;
            capture_done = 1'b0;
            if (!done) cap();
            drain(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
